usb_rx_timer_ctrl: RTL and testbench

USB_RX_TIMER_CTRL -- requirements
Module: usb_rx_timer_ctrl

---
 rtl/usb_rx_timer_ctrl.sv | 100 ++++++++++
 tb/tb_usb_rx_timer_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_timer_ctrl.sv
// USB receive bit timing: locks onto the SYNC falling edge, strobes D+ once per bit period,
// and flags byte boundaries and SE0 end-of-packet. Optional macro RX_EDGE_RESYNC_EN.
`timescale 1ns/1ps
module usb_rx_timer_ctrl #(
    parameter int CLKS_PER_BIT = 8,
    parameter int SAMPLE_POINT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic d_plus_sync,
    input  logic d_minus_sync,
    output logic shift_enable,
    output logic byte_received,
    output logic eop,
    output logic rcving
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_CNT   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] SAMPLE_CNT = CW'(SAMPLE_POINT);

    typedef enum logic [1:0] {IDLE, RUN, EOP_WAIT} state_t;

    state_t        state;
    logic [CW-1:0] clk_cnt;
    logic [CW-1:0] eff_cnt;
    logic [CW-1:0] cnt_next;
    logic [2:0]    bit_cnt;
    logic          d_plus_prev;
    logic          resync;
    logic          start_edge;
    logic          se0;
    logic          at_sample;

    // A resync edge counts as bit position 0, so it can pre-empt a sample on the same cycle.
    always_comb begin
`ifdef RX_EDGE_RESYNC_EN
        resync = (state == RUN) && (d_plus_sync ^ d_plus_prev);
`else
        resync = 1'b0;
`endif
        eff_cnt    = resync ? '0 : clk_cnt;
        cnt_next   = (eff_cnt == LAST_CNT) ? '0 : eff_cnt + CW'(1);
        start_edge = d_plus_prev && !d_plus_sync;
        se0        = !d_plus_sync && !d_minus_sync;
        at_sample  = (state == RUN) && enable && !rst && (eff_cnt == SAMPLE_CNT);
    end

    assign shift_enable  = at_sample && !se0;
    assign eop           = at_sample && se0;
    assign byte_received = shift_enable && (bit_cnt == 3'd7);
    assign rcving        = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            clk_cnt     <= '0;
            bit_cnt     <= '0;
            d_plus_prev <= 1'b1;
        end else begin
            d_plus_prev <= d_plus_sync;
            if (!enable) begin
                state   <= IDLE;
                clk_cnt <= '0;
                bit_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        // The start-edge cycle itself is position 0, so the count resumes at 1.
                        if (start_edge) begin
                            state   <= RUN;
                            clk_cnt <= CW'(1);
                            bit_cnt <= '0;
                        end
                    end
                    RUN: begin
                        if (eop) begin
                            state   <= EOP_WAIT;
                            clk_cnt <= '0;
                            bit_cnt <= '0;
                        end else begin
                            clk_cnt <= cnt_next;
                            if (shift_enable)
                                bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                    EOP_WAIT: begin
                        if (d_plus_sync)
                            state <= IDLE;
                    end
                    default: begin
                        state   <= IDLE;
                        clk_cnt <= '0;
                        bit_cnt <= '0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_usb_rx_timer_ctrl.sv
// Self-checking bench for usb_rx_timer_ctrl: vector table, directed packet scenarios and
// randomized line traffic, all compared against a bit-time arithmetic reference model.
`timescale 1ns/1ps
module tb_usb_rx_timer_ctrl;
    localparam int CPB = 8;
    localparam int SP  = 3;

    logic clk = 1'b0;
    logic rst, enable, d_plus_sync, d_minus_sync;
    logic shift_enable, byte_received, eop, rcving;
    logic [3:0] obs;
    logic [7:0] sync_dp;

    int checks = 0;
    int errors = 0;

    // Reference state: receive mode, the cycle bit timing is anchored to, samples taken.
    int   m_mode;
    int   m_anchor;
    int   m_samples;
    int   m_cyc;
    logic m_prev;
    logic m_valid;

    typedef struct {
        logic       r;
        logic       e;
        logic       dp;
        logic       dm;
        logic [3:0] exp;
    } vec_t;
    vec_t vecs[$];

    usb_rx_timer_ctrl #(.CLKS_PER_BIT(CPB), .SAMPLE_POINT(SP)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .d_plus_sync(d_plus_sync), .d_minus_sync(d_minus_sync),
        .shift_enable(shift_enable), .byte_received(byte_received),
        .eop(eop), .rcving(rcving)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL timeout: bench did not finish, got running expected done");
        $fatal(1, "[TB] timeout");
    end

    task automatic check_output(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %b expected %b", name, m_cyc, act, exp);
        end
    endtask

    // Samples fall every CPB cycles, SP cycles after the anchor; an edge re-anchors when resync is built in.
    task automatic model_step(input logic r, input logic e, input logic dp, input logic dm,
                              input logic [3:0] got);
        logic rcv_x, sample, se0_x, sh_x, br_x, eop_x;
        rcv_x = (m_mode != 0);
`ifdef RX_EDGE_RESYNC_EN
        if (m_mode == 1 && dp != m_prev)
            m_anchor = m_cyc;
`endif
        sample = (m_mode == 1) && e && !r && (((m_cyc - m_anchor) % CPB) == SP);
        se0_x  = !dp && !dm;
        sh_x   = sample && !se0_x;
        eop_x  = sample && se0_x;
        br_x   = sh_x && ((m_samples % 8) == 7);
        if (m_valid) begin
            check_output("model_shift_enable", got[3], sh_x);
            check_output("model_byte_received", got[2], br_x);
            check_output("model_eop", got[1], eop_x);
            check_output("model_rcving", got[0], rcv_x);
        end
        if (r) begin
            m_mode = 0; m_samples = 0; m_valid = 1'b1;
        end else if (!e) begin
            m_mode = 0; m_samples = 0;
        end else if (m_mode == 0) begin
            if (m_prev && !dp) begin
                m_mode = 1; m_anchor = m_cyc; m_samples = 0;
            end
        end else if (m_mode == 1) begin
            if (eop_x) begin
                m_mode = 2; m_samples = 0;
            end else if (sh_x) begin
                m_samples++;
            end
        end else if (dp) begin
            m_mode = 0;
        end
        m_prev = r ? 1'b1 : dp;
        m_cyc++;
    endtask

    task automatic apply_stimulus(input logic r, input logic e, input logic dp, input logic dm,
                                  output logic [3:0] got);
        rst = r; enable = e; d_plus_sync = dp; d_minus_sync = dm;
        @(negedge clk);
        got = {shift_enable, byte_received, eop, rcving};
        model_step(r, e, dp, dm, got);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_line(input int n);
        for (int k = 0; k < n; k++)
            apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, obs);
    endtask

    task automatic end_packet();
        for (int k = 0; k < 16; k++)
            apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, obs);
        for (int k = 0; k < 6; k++)
            apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, obs);
        check_output("end_packet_rcving", obs[0], 1'b0);
    endtask

    function automatic vec_t mk(input logic r, input logic e, input logic dp, input logic dm,
                                input logic [3:0] exp);
        vec_t v;
        v.r = r; v.e = e; v.dp = dp; v.dm = dm; v.exp = exp;
        return v;
    endfunction

    initial begin
        logic dp;
        logic e;
        logic r;
        m_mode = 0; m_anchor = 0; m_samples = 0; m_cyc = 0; m_prev = 1'b1; m_valid = 1'b0;
        sync_dp = 8'b0010_1010;
        rst = 1'b1; enable = 1'b1; d_plus_sync = 1'b1; d_minus_sync = 1'b0;

        // Expected vectors: {shift_enable, byte_received, eop, rcving}
        vecs.push_back(mk(1, 1, 1, 0, 4'b0000));
        vecs.push_back(mk(1, 1, 1, 0, 4'b0000));
        for (int k = 0; k < 20; k++)
            vecs.push_back(mk(0, 1, 1, 0, 4'b0000));
        vecs.push_back(mk(0, 1, 0, 1, 4'b0000));
        vecs.push_back(mk(0, 1, 0, 1, 4'b0001));
        vecs.push_back(mk(0, 1, 0, 1, 4'b0001));
        vecs.push_back(mk(0, 1, 0, 1, 4'b1001));
        vecs.push_back(mk(0, 0, 0, 1, 4'b0001));
        vecs.push_back(mk(0, 1, 0, 1, 4'b0000));
        vecs.push_back(mk(0, 1, 1, 0, 4'b0000));
        vecs.push_back(mk(0, 1, 1, 0, 4'b0000));

        @(posedge clk);
        #1;
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, obs);

        $display("[TB] vector table");
        foreach (vecs[k]) begin
            apply_stimulus(vecs[k].r, vecs[k].e, vecs[k].dp, vecs[k].dm, obs);
            check_output("tbl_shift_enable", obs[3], vecs[k].exp[3]);
            check_output("tbl_byte_received", obs[2], vecs[k].exp[2]);
            check_output("tbl_eop", obs[1], vecs[k].exp[1]);
            check_output("tbl_rcving", obs[0], vecs[k].exp[0]);
        end

        $display("[TB] SYNC byte");
        idle_line(6);
        for (int i = 0; i < 64; i++) begin
            dp = sync_dp[i / 8];
            apply_stimulus(1'b0, 1'b1, dp, ~dp, obs);
            check_output("sync_shift_enable", obs[3], (i >= 3) && ((i - 3) % 8 == 0));
            check_output("sync_byte_received", obs[2], i == 59);
        end
        end_packet();

        $display("[TB] SE0 at second sample");
        idle_line(6);
        for (int i = 0; i < 22; i++) begin
            dp = (i >= 20);
            apply_stimulus(1'b0, 1'b1, dp, (i < 8), obs);
            if (i == 3)  check_output("se0_first_shift", obs[3], 1'b1);
            if (i == 11) check_output("se0_eop", obs[1], 1'b1);
            if (i == 11) check_output("se0_no_shift", obs[3], 1'b0);
            if (i >= 8 && i <= 20) check_output("se0_rcving_held", obs[0], 1'b1);
            if (i == 21) check_output("se0_rcving_drop", obs[0], 1'b0);
        end
        idle_line(4);

        $display("[TB] enable drop mid-byte");
        idle_line(6);
        for (int i = 0; i < 41; i++) begin
            dp = (i < 20) ? sync_dp[i / 8] : ((i == 20) ? sync_dp[2] : 1'b1);
            apply_stimulus(1'b0, (i != 20), dp, ~dp, obs);
            if (i == 19) check_output("en_shift_before", obs[3], 1'b1);
            if (i >= 20) check_output("en_no_shift", obs[3], 1'b0);
            if (i >= 20) check_output("en_no_byte", obs[2], 1'b0);
            if (i == 21) check_output("en_rcving_drop", obs[0], 1'b0);
        end

        $display("[TB] late edge");
        idle_line(6);
        for (int i = 0; i < 15; i++) begin
            dp = (i >= 9);
            apply_stimulus(1'b0, 1'b1, dp, ~dp, obs);
            if (i == 3) check_output("late_first_shift", obs[3], 1'b1);
`ifdef RX_EDGE_RESYNC_EN
            if (i == 11) check_output("late_shift_t11", obs[3], 1'b0);
            if (i == 12) check_output("late_shift_t12", obs[3], 1'b1);
`else
            if (i == 11) check_output("late_shift_t11", obs[3], 1'b1);
            if (i == 12) check_output("late_shift_t12", obs[3], 1'b0);
`endif
        end
        end_packet();

        $display("[TB] reset mid-byte");
        idle_line(6);
        for (int i = 0; i < 104; i++) begin
            if (i < 30)      dp = sync_dp[i / 8];
            else if (i < 40) dp = 1'b1;
            else             dp = sync_dp[(i - 40) / 8];
            apply_stimulus((i == 30), 1'b1, dp, ~dp, obs);
            if (i >= 30 && i <= 42) check_output("rst_no_shift", obs[3], 1'b0);
            if (i >= 30 && i <= 42) check_output("rst_no_eop", obs[1], 1'b0);
            if (i == 31) check_output("rst_rcving_drop", obs[0], 1'b0);
            if (i == 43) check_output("rst_restart_shift", obs[3], 1'b1);
            if (i >= 40) check_output("rst_byte_received", obs[2], i == 99);
        end
        end_packet();

        $display("[TB] randomized packets");
        for (int p = 0; p < 40; p++) begin
            int idle_n, nbits, dur, se0_n;
            logic lvl;
            idle_n = $urandom_range(2, 10);
            for (int k = 0; k < idle_n; k++) begin
                r = ($urandom_range(0, 199) == 0);
                e = ($urandom_range(0, 99) != 0);
                apply_stimulus(r, e, 1'b1, 1'b0, obs);
            end
            nbits = $urandom_range(1, 24);
            for (int b = 0; b < nbits; b++) begin
                lvl = (b == 0) ? 1'b0 : 1'($urandom_range(0, 1));
                dur = CPB;
                if ($urandom_range(0, 7) == 0)
                    dur = ($urandom_range(0, 1) == 1) ? CPB + 1 : CPB - 1;
                for (int k = 0; k < dur; k++) begin
                    r = ($urandom_range(0, 199) == 0);
                    e = ($urandom_range(0, 99) != 0);
                    apply_stimulus(r, e, lvl, ~lvl, obs);
                end
            end
            se0_n = $urandom_range(1, 20);
            for (int k = 0; k < se0_n; k++)
                apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, obs);
            for (int k = 0; k < 3; k++)
                apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, obs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
